mem_dados_param: RTL and testbench

Parametrised data memory for the processor's MEM stage. Successor to the fixed 64-word, halfword-only data memory. Adds:
- Full RV32 byte, halfword and word load/store with sign and zero extension.
- Configurable depth and access latency.
- A valid/ready request handshake with a one-cycle response pulse.
- Alignment and range error reporting.

---
 rtl/mem_dados_pkg.sv | 28 ++
 rtl/mem_dados_alinhador.sv | 53 +++++
 rtl/mem_dados_param.sv | 137 +++++++++++++
 tb/tb_mem_dados_param.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_dados_pkg.sv
// rtl/mem_dados_pkg.sv - shared types, funct3 codes and byte-enable helper for the data memory
package mem_dados_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        OCIOSO,
        ESPERA,
        RESPONDE
    } estado_t;

    function automatic logic [3:0] habilita_bytes(input logic [2:0] funct3,
                                                  input logic [1:0] end_lsb);
        logic [3:0] be;
        case (funct3)
            F3_B, F3_BU: be = 4'b0001 << end_lsb;
            F3_H, F3_HU: be = end_lsb[1] ? 4'b1100 : 4'b0011;
            F3_W:        be = 4'b1111;
            default:     be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_dados_alinhador.sv
// rtl/mem_dados_alinhador.sv - lane selection, load extension, store replication and alignment check
module mem_dados_alinhador
    import mem_dados_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic        escrita,
    input  logic [1:0]  end_lsb,
    input  logic [31:0] palavra,
    input  logic [31:0] valor_reg2,
    output logic [31:0] dado_carga,
    output logic [3:0]  habilita,
    output logic [31:0] dado_escrita,
    output logic        erro_alinh
);

    logic [7:0]  byte_sel;
    logic [15:0] meia_sel;
    logic        erro_funct;

    always_comb begin
        byte_sel = palavra[{end_lsb, 3'b000} +: 8];
        meia_sel = end_lsb[1] ? palavra[31:16] : palavra[15:0];

        // Unsigned variants only exist for loads.
        if (escrita)
            erro_funct = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W);
        else
            erro_funct = !(funct3 == F3_B || funct3 == F3_H || funct3 == F3_W ||
                           funct3 == F3_BU || funct3 == F3_HU);

        erro_alinh = erro_funct
                   | (((funct3 == F3_H) || (funct3 == F3_HU)) & end_lsb[0])
                   | ((funct3 == F3_W) & (end_lsb != 2'b00));

        habilita = erro_alinh ? 4'b0000 : habilita_bytes(funct3, end_lsb);

        case (funct3)
            F3_B, F3_BU: dado_escrita = {4{valor_reg2[7:0]}};
            F3_H, F3_HU: dado_escrita = {2{valor_reg2[15:0]}};
            default:     dado_escrita = valor_reg2;
        endcase

        case (funct3)
            F3_B:    dado_carga = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   dado_carga = {24'h0, byte_sel};
            F3_H:    dado_carga = {{16{meia_sel[15]}}, meia_sel};
            F3_HU:   dado_carga = {16'h0, meia_sel};
            F3_W:    dado_carga = palavra;
            default: dado_carga = 32'h0;
        endcase
    end

endmodule

// File: rtl/mem_dados_param.sv
// rtl/mem_dados_param.sv - parametrised MEM-stage data memory with valid/ready request and response pulse
module mem_dados_param
    import mem_dados_pkg::*;
#(
    parameter int NUM_PALAVRAS = 64,
    parameter int LATENCIA     = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valido,
    output logic        req_pronto,
    input  logic        escrita,
    input  logic [2:0]  funct3,
    input  logic [31:0] endereco,
    input  logic [31:0] valor_reg2,
    output logic        resp_valido,
    output logic [31:0] dado_saida,
    output logic        erro
);

    localparam int AW = $clog2(NUM_PALAVRAS);
    localparam int CW = (LATENCIA > 1) ? $clog2(LATENCIA) : 1;
    localparam logic [CW-1:0] CONT_INI = CW'(LATENCIA - 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] contador_q, contador_d;
    logic          escrita_q, escrita_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [31:0]   endereco_q, endereco_d;
    logic [31:0]   valor_q, valor_d;
    logic          resp_valido_q, resp_valido_d;
    logic [31:0]   dado_saida_q, dado_saida_d;
    logic          erro_q, erro_d;

    logic [31:0] mem [NUM_PALAVRAS];
    logic [AW-1:0] indice;
    logic [31:0] palavra;
    logic [31:0] dado_carga;
    logic [31:0] dado_escrita;
    logic [3:0]  habilita;
    logic        erro_alinh;
    logic        fora_faixa;
    logic        escreve;

    assign indice     = endereco_q[2 +: AW];
    assign palavra    = mem[indice];
    // Depth is a power of two, so any set bit above the index means out of range.
    assign fora_faixa = |endereco_q[31:2+AW];

    mem_dados_alinhador u_alinhador (
        .funct3       (funct3_q),
        .escrita      (escrita_q),
        .end_lsb      (endereco_q[1:0]),
        .palavra      (palavra),
        .valor_reg2   (valor_q),
        .dado_carga   (dado_carga),
        .habilita     (habilita),
        .dado_escrita (dado_escrita),
        .erro_alinh   (erro_alinh)
    );

    always_comb begin
        estado_d      = estado_q;
        contador_d    = contador_q;
        escrita_d     = escrita_q;
        funct3_d      = funct3_q;
        endereco_d    = endereco_q;
        valor_d       = valor_q;
        resp_valido_d = 1'b0;
        dado_saida_d  = dado_saida_q;
        erro_d        = erro_q;
        escreve       = 1'b0;

        case (estado_q)
            OCIOSO: begin
                if (req_valido) begin
                    escrita_d  = escrita;
                    funct3_d   = funct3;
                    endereco_d = endereco;
                    valor_d    = valor_reg2;
                    contador_d = CONT_INI;
                    estado_d   = ESPERA;
                end
            end
            ESPERA: begin
                if (contador_q != '0) begin
                    contador_d = contador_q - CW'(1);
                end else begin
                    erro_d        = erro_alinh | fora_faixa;
                    dado_saida_d  = (erro_alinh | fora_faixa | escrita_q) ? 32'h0 : dado_carga;
                    escreve       = escrita_q & ~(erro_alinh | fora_faixa) & ~reset;
                    resp_valido_d = 1'b1;
                    estado_d      = RESPONDE;
                end
            end
            RESPONDE: estado_d = OCIOSO;
            default:  estado_d = OCIOSO;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            estado_q      <= OCIOSO;
            contador_q    <= '0;
            escrita_q     <= 1'b0;
            funct3_q      <= 3'b000;
            endereco_q    <= 32'h0;
            valor_q       <= 32'h0;
            resp_valido_q <= 1'b0;
            dado_saida_q  <= 32'h0;
            erro_q        <= 1'b0;
        end else begin
            estado_q      <= estado_d;
            contador_q    <= contador_d;
            escrita_q     <= escrita_d;
            funct3_q      <= funct3_d;
            endereco_q    <= endereco_d;
            valor_q       <= valor_d;
            resp_valido_q <= resp_valido_d;
            dado_saida_q  <= dado_saida_d;
            erro_q        <= erro_d;
        end
    end

    always_ff @(posedge clock) begin
        for (int k = 0; k < 4; k++) begin
            if (escreve && habilita[k])
                mem[indice][8*k +: 8] <= dado_escrita[8*k +: 8];
        end
    end

    assign req_pronto  = (estado_q == OCIOSO);
    assign resp_valido = resp_valido_q;
    assign dado_saida  = dado_saida_q;
    assign erro        = erro_q;

endmodule

// File: tb/tb_mem_dados_param.sv
// tb/tb_mem_dados_param.sv - randomized and directed bench for mem_dados_param with a byte-level reference model
module tb_mem_dados_param;

    logic        clock = 1'b0;
    logic        reset;
    logic        req_valido [2];
    logic        escrita    [2];
    logic [2:0]  funct3     [2];
    logic [31:0] endereco   [2];
    logic [31:0] valor_reg2 [2];
    logic        req_pronto [2];
    logic        resp_valido[2];
    logic [31:0] dado_saida [2];
    logic        erro       [2];

    always #5 clock = ~clock;

    mem_dados_param #(.NUM_PALAVRAS(64), .LATENCIA(1)) dut_l1 (
        .clock(clock), .reset(reset),
        .req_valido(req_valido[0]), .req_pronto(req_pronto[0]),
        .escrita(escrita[0]), .funct3(funct3[0]), .endereco(endereco[0]),
        .valor_reg2(valor_reg2[0]), .resp_valido(resp_valido[0]),
        .dado_saida(dado_saida[0]), .erro(erro[0])
    );

    mem_dados_param #(.NUM_PALAVRAS(64), .LATENCIA(3)) dut_l3 (
        .clock(clock), .reset(reset),
        .req_valido(req_valido[1]), .req_pronto(req_pronto[1]),
        .escrita(escrita[1]), .funct3(funct3[1]), .endereco(endereco[1]),
        .valor_reg2(valor_reg2[1]), .resp_valido(resp_valido[1]),
        .dado_saida(dado_saida[1]), .erro(erro[1])
    );

    // Reference model: plain byte array per instance, 64 words = 256 bytes.
    logic [7:0]  mb [2][256];
    int          cyc = 0;
    bit          pend [2];
    int          due  [2];
    logic [31:0] exp_d [2];
    bit          exp_e [2];
    bit          pend_wr [2];
    int          pend_addr [2];
    int          pend_sz [2];
    logic [31:0] pend_val [2];
    int          n_resp [2];
    logic [31:0] last_d [2];
    logic        last_e [2];
    int          acc_cyc [2];
    int          prev_acc_cyc [2];
    int          n_vec = 0;
    int          n_err = 0;

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int tamanho(input bit wr, input logic [2:0] f3);
        int sz;
        case (f3)
            3'b000, 3'b100: sz = 1;
            3'b001, 3'b101: sz = 2;
            3'b010:         sz = 4;
            default:        sz = 0;
        endcase
        if (wr && f3[2]) sz = 0;
        return sz;
    endfunction

    task automatic modelo(input int i, input bit wr, input logic [2:0] f3,
                          input logic [31:0] a, input logic [31:0] v);
        int sz;
        bit bad;
        logic [31:0] r;
        sz = tamanho(wr, f3);
        bad = (sz == 0);
        if (!bad) bad = ((a % sz) != 0) || ((a / 4) >= 64);
        r = 32'h0;
        if (!bad && !wr) begin
            for (int k = 0; k < sz; k++) r = r | (32'(mb[i][int'(a) + k]) << (8 * k));
            if (!f3[2] && sz < 4 && r[8*sz-1]) r = r | ~((32'd1 << (8 * sz)) - 32'd1);
        end
        exp_d[i]     = r;
        exp_e[i]     = bad;
        pend_wr[i]   = wr && !bad;
        pend_addr[i] = int'(a);
        pend_sz[i]   = sz;
        pend_val[i]  = v;
    endtask

    always @(posedge clock) cyc++;

    always @(negedge clock) begin
        for (int i = 0; i < 2; i++) begin
            bit rdy;
            bit exp_r;
            if (reset) begin
                pend[i] = 1'b0;
                n_vec++;
                if (req_pronto[i] !== 1'b1 || resp_valido[i] !== 1'b0 ||
                    dado_saida[i] !== 32'h0 || erro[i] !== 1'b0) begin
                    n_err++;
                    $display("FAIL reset_state[%0d] cyc %0d: pronto=%b resp=%b dado=%h erro=%b required 1 0 0 0",
                             i, cyc, req_pronto[i], resp_valido[i], dado_saida[i], erro[i]);
                end
            end else begin
                rdy   = !pend[i];
                exp_r = pend[i] && (cyc == due[i]);
                n_vec++;
                if (req_pronto[i] !== rdy) begin
                    n_err++;
                    $display("FAIL req_pronto[%0d] cyc %0d: got %b required %b", i, cyc, req_pronto[i], rdy);
                end
                n_vec++;
                if (resp_valido[i] !== exp_r) begin
                    n_err++;
                    $display("FAIL resp_valido[%0d] cyc %0d: got %b required %b", i, cyc, resp_valido[i], exp_r);
                end
                if (exp_r) begin
                    n_vec++;
                    if (dado_saida[i] !== exp_d[i] || erro[i] !== exp_e[i]) begin
                        n_err++;
                        $display("FAIL resposta[%0d] cyc %0d: got dado=%h erro=%b required dado=%h erro=%b",
                                 i, cyc, dado_saida[i], erro[i], exp_d[i], exp_e[i]);
                    end
                    if (pend_wr[i])
                        for (int k = 0; k < pend_sz[i]; k++)
                            mb[i][pend_addr[i] + k] = pend_val[i][8*k +: 8];
                    pend[i]   = 1'b0;
                    last_d[i] = dado_saida[i];
                    last_e[i] = erro[i];
                    n_resp[i]++;
                end
                if (req_valido[i] && rdy) begin
                    modelo(i, escrita[i], funct3[i], endereco[i], valor_reg2[i]);
                    pend[i]         = 1'b1;
                    due[i]          = cyc + 1 + lat(i);
                    prev_acc_cyc[i] = acc_cyc[i];
                    acc_cyc[i]      = cyc + 1;
                end
            end
        end
    end

    task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] req);
        n_vec++;
        if (got !== req) begin
            n_err++;
            $display("FAIL %s: got %h required %h", nome, got, req);
        end
    endtask

    // Called #1 after a rising edge; returns #1 after acceptance (or after the response).
    task automatic req(input int i, input bit wr, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] v, input bit espera);
        int n;
        int base;
        n = 0;
        while (!req_pronto[i] && n < 50) begin @(posedge clock); #1; n++; end
        n_vec++;
        if (n >= 50) begin n_err++; $display("FAIL timeout_pronto[%0d]: got 0 required 1", i); end
        base          = n_resp[i];
        escrita[i]    = wr;
        funct3[i]     = f3;
        endereco[i]   = a;
        valor_reg2[i] = v;
        req_valido[i] = 1'b1;
        @(posedge clock); #1;
        req_valido[i] = 1'b0;
        escrita[i]    = 1'($urandom);
        funct3[i]     = 3'($urandom);
        endereco[i]   = $urandom;
        valor_reg2[i] = $urandom;
        if (espera) begin
            n = 0;
            while (n_resp[i] == base && n < 20) begin @(posedge clock); #1; n++; end
            n_vec++;
            if (n_resp[i] == base) begin n_err++; $display("FAIL timeout_resp[%0d]: got none required 1", i); end
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req_valido[i] = 1'b0; escrita[i] = 1'b0; funct3[i] = 3'b0;
            endereco[i] = 32'h0; valor_reg2[i] = 32'h0;
            pend[i] = 1'b0; n_resp[i] = 0; acc_cyc[i] = 0; prev_acc_cyc[i] = 0;
            for (int b = 0; b < 256; b++) mb[i][b] = 8'h00;
        end
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        for (int w = 0; w < 64; w++) begin
            req(0, 1, 3'b010, 32'(w * 4), 32'h0, 1);
            req(1, 1, 3'b010, 32'(w * 4), 32'h0, 1);
        end

        req(0, 1, 3'b010, 32'h10, 32'h8000_00FF, 1);
        req(0, 0, 3'b010, 32'h10, 32'h0, 1);
        chk("t1_lw", last_d[0], 32'h8000_00FF);
        chk("t1_erro", 32'(last_e[0]), 32'h0);

        req(0, 1, 3'b000, 32'h21, 32'h0000_0080, 1);
        req(0, 0, 3'b010, 32'h20, 32'h0, 1);
        chk("t2_lw", last_d[0], 32'h0000_8000);
        req(0, 0, 3'b000, 32'h21, 32'h0, 1);
        chk("t2_lb", last_d[0], 32'hFFFF_FF80);
        req(0, 0, 3'b100, 32'h21, 32'h0, 1);
        chk("t2_lbu", last_d[0], 32'h0000_0080);

        req(0, 1, 3'b001, 32'h32, 32'h0000_BEEF, 1);
        req(0, 0, 3'b001, 32'h32, 32'h0, 1);
        chk("t3_lh", last_d[0], 32'hFFFF_BEEF);
        req(0, 0, 3'b101, 32'h32, 32'h0, 1);
        chk("t3_lhu", last_d[0], 32'h0000_BEEF);
        req(0, 0, 3'b001, 32'h33, 32'h0, 1);
        chk("t3_lh_desalinhado_erro", 32'(last_e[0]), 32'h1);
        chk("t3_lh_desalinhado_dado", last_d[0], 32'h0);

        req(0, 1, 3'b010, 32'h0, 32'h1122_3344, 1);
        req(0, 1, 3'b010, 32'h100, 32'hDEAD_BEEF, 1);
        chk("t4_fora_faixa_erro", 32'(last_e[0]), 32'h1);
        req(0, 0, 3'b010, 32'h0, 32'h0, 1);
        chk("t4_sem_wrap", last_d[0], 32'h1122_3344);

        // Request held high continuously: back-to-back accepts must be LATENCIA+2 apart.
        escrita[1] = 1'b1; funct3[1] = 3'b010; endereco[1] = 32'h4; valor_reg2[1] = 32'h1234_5678;
        req_valido[1] = 1'b1;
        repeat (12) begin @(posedge clock); #1; end
        req_valido[1] = 1'b0;
        n = 0;
        while (pend[1] && n < 20) begin @(posedge clock); #1; n++; end
        chk("t5_intervalo", 32'(acc_cyc[1] - prev_acc_cyc[1]), 32'd5);
        req(1, 0, 3'b010, 32'h4, 32'h0, 1);
        chk("t5_lw", last_d[1], 32'h1234_5678);

        req(1, 1, 3'b010, 32'h8, 32'hAAAA_AAAA, 0);
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        req(1, 0, 3'b010, 32'h8, 32'h0, 1);
        chk("t6_abandonado", last_d[1], 32'h0);

        for (int t = 0; t < 400; t++) begin
            int i;
            logic [31:0] a;
            i = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else a = 32'($urandom_range(0, 280));
            req(i, 1'($urandom), 3'($urandom), a, $urandom, 1);
        end

        repeat (5) @(posedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
